// File: rtl/dcache_result_checker_if.sv
// Data-cache write stream and golden-table load bus feeding dcache_result_checker.
interface dcache_result_checker_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
);
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              ld_en;
    logic [IDX_W-1:0]  ld_idx;
    logic [DATA_W-1:0] ld_data;

    modport master (output wr_addr, wr_data, wr_en, ld_en, ld_idx, ld_data);
    modport slave  (input  wr_addr, wr_data, wr_en, ld_en, ld_idx, ld_data);
endinterface

// File: rtl/dcache_result_checker.sv
// Compares cache writes landing in the answer window against a golden table and raises finish.
// Optional first-mismatch capture ports are enabled by defining CHECKER_FIRST_ERR_EN.
module dcache_result_checker #(
    parameter int                ADDR_W    = 30,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 30'h40,
    parameter logic [15:0]       TIMEOUT   = 16'hFFF0
) (
    input  logic                     clk,
    input  logic                     rst,
    dcache_result_checker_if.slave   bus_i,
    output logic [7:0]               error_num_o,
    output logic [15:0]              duration_o,
    output logic                     finish_o,
    output logic                     timeout_o,
    output logic                     busy_o
`ifdef CHECKER_FIRST_ERR_EN
    ,
    output logic [ADDR_W-1:0]        first_err_addr_o,
    output logic [DATA_W-1:0]        first_err_data_o
`endif
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DEPTH-1:0]  seen_q, seen_d;
    logic [7:0]        error_num_q, error_num_d;
    logic [15:0]       duration_q, duration_d;
    logic              finish_q, finish_d;
    logic              timeout_q, timeout_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] table_q [DEPTH];

    logic [ADDR_W-1:0] offset_s;
    logic              hit_s;
    logic              mismatch_s;

    // Window decode; the subtraction is only trusted once wr_addr >= BASE_ADDR.
    assign offset_s   = bus_i.wr_addr - BASE_ADDR;
    assign hit_s      = bus_i.wr_en && (bus_i.wr_addr >= BASE_ADDR) && (offset_s < ADDR_W'(DEPTH));
    assign mismatch_s = valid_q && (table_q[idx_q] != data_q);

    // Next-state, pipeline capture, compare and counter update.
    always_comb begin
        state_d     = state_q;
        valid_d     = 1'b0;
        idx_d       = idx_q;
        data_d      = data_q;
        seen_d      = seen_q;
        error_num_d = error_num_q;
        duration_d  = duration_q;
        finish_d    = finish_q;
        timeout_d   = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (bus_i.wr_en) begin
                    state_d    = S_RUN;
                    duration_d = sat_inc16(duration_q);
                    valid_d    = hit_s;
                    idx_d      = offset_s[IDX_W-1:0];
                    data_d     = bus_i.wr_data;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                duration_d = sat_inc16(duration_q);
                if (valid_q) begin
                    seen_d[idx_q] = 1'b1;
                    error_num_d   = mismatch_s ? sat_inc8(error_num_q) : error_num_q;
                end else begin
                    seen_d = seen_q;
                end
                // Completion outranks timeout; a hit sampled on the exit edge is dropped.
                if (&seen_d) begin
                    state_d   = S_DONE;
                    finish_d  = 1'b1;
                    timeout_d = 1'b0;
                end else if (duration_q == (TIMEOUT - 16'd1)) begin
                    state_d   = S_DONE;
                    finish_d  = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    valid_d = hit_s;
                    idx_d   = offset_s[IDX_W-1:0];
                    data_d  = bus_i.wr_data;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN);
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            valid_q     <= 1'b0;
            idx_q       <= '0;
            data_q      <= '0;
            seen_q      <= '0;
            error_num_q <= 8'd0;
            duration_q  <= 16'd0;
            finish_q    <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            seen_q      <= seen_d;
            error_num_q <= error_num_d;
            duration_q  <= duration_d;
            finish_q    <= finish_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    // Golden table is plain RAM: loadable only while idle, survives reset.
    always_ff @(posedge clk) begin
        if ((state_q == S_IDLE) && bus_i.ld_en) begin
            table_q[bus_i.ld_idx] <= bus_i.ld_data;
        end
    end

    assign error_num_o = error_num_q;
    assign duration_o  = duration_q;
    assign finish_o    = finish_q;
    assign timeout_o   = timeout_q;
    assign busy_o      = busy_q;

`ifdef CHECKER_FIRST_ERR_EN
    logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
    logic [DATA_W-1:0] first_err_data_q, first_err_data_d;

    // A zero error count means this compare is the first mismatch since reset.
    always_comb begin
        first_err_addr_d = first_err_addr_q;
        first_err_data_d = first_err_data_q;
        if ((state_q == S_RUN) && mismatch_s && (error_num_q == 8'd0)) begin
            first_err_addr_d = BASE_ADDR + ADDR_W'(idx_q);
            first_err_data_d = data_q;
        end else begin
            first_err_addr_d = first_err_addr_q;
            first_err_data_d = first_err_data_q;
        end
    end

    // First-mismatch capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_err_addr_q <= '0;
            first_err_data_q <= '0;
        end else begin
            first_err_addr_q <= first_err_addr_d;
            first_err_data_q <= first_err_data_d;
        end
    end

    assign first_err_addr_o = first_err_addr_q;
    assign first_err_data_o = first_err_data_q;
`endif
endmodule
